adc_frame_packer: RTL and testbench
===================================

# adc_frame_packer

Downstream consumer of the 7-channel filtered ADC array. Snapshots all seven 12-bit channel values on a periodic tick or explicit request and serialises them as a fixed 17-byte telemetry frame over a byte-wide valid/ready stream. The stream feeds the UART transmitter. Runs in the 1 MHz ADC clock domain, so no clock crossing is needed on the channel array.

## Interface

**Parameters**
- `PERIOD`, default 10000: clock cycles between automatic frame triggers. 0 disables auto-trigger.
- `SYNC_BYTE`, default 8'hA5: first byte of every frame.

**Ports**
- `c1m` in, 1: clock, 1 MHz ADC clock.
- `rst` in, 1: reset, synchronous, active-high.
- `adc_data` in, [11:0] x [6:0]: filtered channel values, channel 0..6.
- `start` in, 1: single-cycle frame request.
- `tx_ready` in, 1: sink accepts `tx_data` this cycle.
- `tx_data` out, 8: current frame byte.
- `tx_valid` out, 1: `tx_data` is valid.
- `busy` out, 1: frame in progress (state is not IDLE).
- `frame_done` out, 1: one-cycle pulse after the last byte is accepted.
- `overrun` out, 1: one-cycle pulse when a trigger is dropped.

## Operation

**Frame layout** (byte index 0..16):
- Byte 0: `SYNC_BYTE`.
- Byte 1: 8-bit sequence number `seq`.
- Bytes 2..15: channel k high byte {4'b0, ch[11:8]} at 2+2k, then low byte ch[7:0] at 3+2k.
- Byte 16: checksum, the modulo-256 sum of bytes 1..15. The sync byte is excluded.

**Trigger**
- Trigger = `start` OR auto_tick.
- Period counter runs 0..PERIOD-1 continuously, including while busy.
- auto_tick is asserted in the cycle the counter equals PERIOD-1; the counter then wraps to 0.

**FSM: IDLE, SEND**
- IDLE + trigger:
  - Capture all 7 channels into shadow registers.
  - Clear the checksum accumulator and set byte index to 0.
  - Go to SEND.
- IDLE, no trigger: stay.
- SEND:
  - `tx_valid` = 1 and `tx_data` = byte[index], driven from shadow registers only. Live `adc_data` changes mid-frame have no effect.
  - Accept = `tx_valid` & `tx_ready`.
  - On accept: index+1, and add the byte to the checksum if index is in 1..15.
  - On accept of index 16: go to IDLE, `seq` <= `seq`+1 (255 wraps to 0), pulse `frame_done` next cycle.
- Trigger while in SEND, including the cycle of the last-byte accept: trigger is dropped and `overrun` pulses next cycle. The shadow registers are unaffected.
- `start` and auto_tick in the same cycle count as one trigger.

**Handshake rules**
- While `tx_valid` = 1 and `tx_ready` = 0, `tx_data` is held stable.
- `tx_valid` never deasserts mid-frame.
- `tx_ready` is ignored when `tx_valid` = 0.

**Reset**
- Next edge after `rst` = 1:
  - State IDLE; `seq`, index, checksum and period counter cleared to 0.
  - All outputs 0: `tx_data` 8'h00, `tx_valid`, `busy`, `frame_done`, `overrun`.
- Reset mid-frame aborts the frame with no `frame_done` pulse, and `seq` returns to 0.
- A trigger in the reset cycle is ignored.

## Timing

- Trigger sampled in IDLE at edge N → `tx_valid` = 1 with byte 0 from edge N+1.
- With `tx_ready` held at 1: one byte per cycle, frame occupies 17 cycles.
  - Last accept at edge N+17.
  - `frame_done` = 1 and `busy` = 0 during cycle N+18.
  - Earliest next trigger is sampled at N+18.
- The checksum byte is ready when index reaches 16. Accumulation happens on accept, so no extra cycle is inserted.
- `overrun` and `frame_done` are registered pulses, exactly 1 cycle wide.
- Minimum useful `PERIOD` is 18. Smaller nonzero values produce an overrun on some ticks.

## Test plan

1. **Reset and first frame.** Reset, then `start` with all channels = 12'hFFF, `tx_ready` = 1. Expect bytes A5 00 (0F FF)x7 62, then a `frame_done` pulse, and the next frame carries `seq` = 01.
2. **Backpressure.** Toggle `tx_ready` randomly and set channel k = 12'h100·k+12'h023. Expect `tx_data` stable while stalled, byte order 0x0k,0x23 per channel, and a checksum that matches the reference sum.
3. **Snapshot isolation.** Change every `adc_data` value after the trigger cycle. Expect the frame to carry the values captured at the trigger cycle.
4. **Overrun.** Pulse `start` during byte 5, and again in the last-accept cycle. Expect two `overrun` pulses, a frame that completes unchanged, and no new frame started.
5. **Periodic operation.** With `PERIOD` = 20 and `tx_ready` = 1, expect frames every 20 cycles, no overrun, and `seq` wrapping FF→00 after 256 frames.
6. **Reset mid-frame.** Assert `rst` at byte 9. Expect `tx_valid` = 0 next cycle, no `frame_done`, and the following frame starting with A5 00.

Source files
------------

// File: rtl/adc_frame_packer.sv
// adc_frame_packer: snapshots seven 12-bit ADC channels on a periodic tick or
// on request, and streams them as a 17-byte checksummed frame (valid/ready).
`timescale 1ns/1ps
module adc_frame_packer #(
  parameter int unsigned PERIOD    = 10000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic             c1m,
  input  logic             rst,
  input  logic [6:0][11:0] adc_data,
  input  logic             start,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           r_state;
  logic [31:0]      r_per_cnt;
  logic [6:0][11:0] r_shadow;
  logic [4:0]       r_idx;
  logic [7:0]       r_csum;
  logic [7:0]       r_seq;
  logic [7:0]       r_tx_data;
  logic             r_tx_valid;
  logic             r_busy;
  logic             r_frame_done;
  logic             r_overrun;

  logic             w_auto_tick;
  logic             w_trigger;
  logic             w_accept;
  logic [4:0]       w_idx_nxt;
  logic [7:0]       w_csum_nxt;
  logic [7:0]       w_byte_nxt;

  assign w_auto_tick = (PERIOD != 0) && (r_per_cnt == 32'(PERIOD - 1));
  assign w_trigger   = start | w_auto_tick;
  assign w_accept    = r_tx_valid & tx_ready;

  // Free-running period counter, independent of the frame state.
  always_ff @(posedge c1m) begin
    if (rst) begin
      r_per_cnt <= '0;
    end else if (w_auto_tick || (PERIOD == 0)) begin
      r_per_cnt <= '0;
    end else begin
      r_per_cnt <= r_per_cnt + 32'd1;
    end
  end

  // tx_data is registered, so the byte for index+1 is formed one accept ahead;
  // the checksum byte therefore uses the sum including the byte being accepted.
  always_comb begin
    w_idx_nxt  = r_idx + 5'd1;
    w_csum_nxt = r_csum;
    if ((r_idx >= 5'd1) && (r_idx <= 5'd15)) begin
      w_csum_nxt = r_csum + r_tx_data;
    end
    w_byte_nxt = w_csum_nxt;
    if (w_idx_nxt == 5'd1) begin
      w_byte_nxt = r_seq;
    end
    for (int unsigned k = 0; k < 7; k++) begin
      if (w_idx_nxt == 5'(2 + 2 * k)) begin
        w_byte_nxt = {4'h0, r_shadow[k][11:8]};
      end
      if (w_idx_nxt == 5'(3 + 2 * k)) begin
        w_byte_nxt = r_shadow[k][7:0];
      end
    end
  end

  always_ff @(posedge c1m) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shadow     <= '0;
      r_idx        <= '0;
      r_csum       <= '0;
      r_seq        <= '0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_shadow   <= adc_data;
            r_csum     <= '0;
            r_idx      <= '0;
            r_tx_data  <= SYNC_BYTE;
            r_tx_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= SEND;
          end
        end
        SEND: begin
          r_overrun <= w_trigger;
          if (w_accept) begin
            r_csum <= w_csum_nxt;
            if (r_idx == 5'd16) begin
              r_state      <= IDLE;
              r_tx_valid   <= 1'b0;
              r_busy       <= 1'b0;
              r_tx_data    <= '0;
              r_seq        <= r_seq + 8'd1;
              r_frame_done <= 1'b1;
            end else begin
              r_idx     <= w_idx_nxt;
              r_tx_data <= w_byte_nxt;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Testbench for adc_frame_packer: one instance with auto-trigger disabled for
// directed/random frames, one with PERIOD=20 for periodic operation.
`timescale 1ns/1ps
module tb_adc_frame_packer;

  typedef logic [7:0]  frame_t [17];
  typedef logic [11:0] chans_t [7];

  logic             c1m = 1'b0;
  logic             rst, start, tx_ready;
  logic [6:0][11:0] adc_data;
  logic [7:0]       tx_data;
  logic             tx_valid, busy, frame_done, overrun;

  logic             rst_p, start_p, tx_ready_p;
  logic [6:0][11:0] adc_p;
  logic [7:0]       tx_data_p;
  logic             tx_valid_p, busy_p, frame_done_p, overrun_p;

  int checks = 0;
  int errors = 0;

  always #5 c1m = ~c1m;

  adc_frame_packer #(.PERIOD(0), .SYNC_BYTE(8'hA5)) dut (
    .c1m(c1m), .rst(rst), .adc_data(adc_data), .start(start),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  adc_frame_packer #(.PERIOD(20), .SYNC_BYTE(8'hA5)) dut_p (
    .c1m(c1m), .rst(rst_p), .adc_data(adc_p), .start(start_p),
    .tx_ready(tx_ready_p), .tx_data(tx_data_p), .tx_valid(tx_valid_p),
    .busy(busy_p), .frame_done(frame_done_p), .overrun(overrun_p)
  );

  // Reference frame: layout and checksum computed directly from the frame rules.
  function automatic frame_t build_frame(input chans_t ch, input logic [7:0] seq);
    frame_t f;
    int     sum;
    f[0] = 8'hA5;
    f[1] = seq;
    sum  = int'(seq);
    for (int k = 0; k < 7; k++) begin
      f[2 + 2 * k] = {4'h0, ch[k][11:8]};
      f[3 + 2 * k] = ch[k][7:0];
      sum += int'(ch[k][11:8]) + int'(ch[k][7:0]);
    end
    f[16] = 8'(sum % 256);
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_adc(input chans_t ch);
    for (int k = 0; k < 7; k++) adc_data[k] = ch[k];
  endtask

  function automatic chans_t rand_chans();
    chans_t ch;
    for (int k = 0; k < 7; k++) ch[k] = 12'($urandom);
    return ch;
  endfunction

  // Entered at a negedge with start=1 already driven for the coming edge.
  task automatic recv_frame(input frame_t exp, input int rdy_pct, input int ovr_byte,
                            input bit ovr_last, input bit scramble, input string tag);
    int idx;
    int cyc;
    bit exp_ovr;
    bit pulsed;
    bit rdy;
    idx = 0; cyc = 0; exp_ovr = 0; pulsed = 0;
    @(negedge c1m);
    start = 1'b0;
    chk({tag, " busy-after-trigger"}, 32'(busy), 32'd1);
    while (idx < 17 && cyc < 400) begin
      if (scramble) drive_adc(rand_chans());
      chk({tag, " valid"}, 32'(tx_valid), 32'd1);
      chk($sformatf("%s byte%0d", tag, idx), 32'(tx_data), 32'(exp[idx]));
      chk({tag, " overrun"}, 32'(overrun), 32'(exp_ovr));
      rdy     = ($urandom_range(99) < rdy_pct);
      start   = 1'b0;
      exp_ovr = 1'b0;
      if (idx == ovr_byte && !pulsed) begin
        start = 1'b1; pulsed = 1'b1; exp_ovr = 1'b1;
      end
      if (idx == 16 && ovr_last) begin
        rdy = 1'b1; start = 1'b1; exp_ovr = 1'b1;
      end
      tx_ready = rdy;
      @(negedge c1m);
      cyc++;
      if (rdy) idx++;
    end
    start = 1'b0;
    chk({tag, " frame-within-budget"}, 32'(idx), 32'd17);
    chk({tag, " frame_done"}, 32'(frame_done), 32'd1);
    chk({tag, " busy-end"}, 32'(busy), 32'd0);
    chk({tag, " valid-end"}, 32'(tx_valid), 32'd0);
    chk({tag, " overrun-end"}, 32'(overrun), 32'(exp_ovr));
    tx_ready = 1'($urandom);
    @(negedge c1m);
    chk({tag, " frame_done-1cycle"}, 32'(frame_done), 32'd0);
    chk({tag, " no-new-frame"}, 32'(tx_valid), 32'd0);
    chk({tag, " busy-idle"}, 32'(busy), 32'd0);
    chk({tag, " overrun-1cycle"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    chans_t      ch;
    chans_t      pch;
    frame_t      expf;
    logic [7:0]  seq;
    int          cyc, bi, fn, dones;

    rst = 1'b1; start = 1'b0; tx_ready = 1'b0; adc_data = '0;
    rst_p = 1'b1; start_p = 1'b0; tx_ready_p = 1'b1; adc_p = '0;
    seq = 8'd0;

    // Reset state, with a trigger held during reset that must be ignored.
    @(negedge c1m);
    start = 1'b1;
    @(negedge c1m);
    chk("reset tx_data", 32'(tx_data), 32'h00);
    chk("reset tx_valid", 32'(tx_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset frame_done", 32'(frame_done), 32'd0);
    chk("reset overrun", 32'(overrun), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge c1m);
    chk("trigger-in-reset ignored", 32'(tx_valid), 32'd0);

    // First frame with all channels full scale, then the next sequence number.
    for (int k = 0; k < 7; k++) ch[k] = 12'hFFF;
    drive_adc(ch);
    tx_ready = 1'b1;
    expf = build_frame(ch, seq);
    chk("model checksum FFF", 32'(expf[16]), 32'h62);
    start = 1'b1;
    recv_frame(expf, 100, -1, 1'b0, 1'b0, "t1");
    seq++;
    start = 1'b1;
    recv_frame(build_frame(ch, seq), 100, -1, 1'b0, 1'b0, "t1-seq1");
    seq++;

    // Backpressure with a recognisable channel pattern.
    for (int k = 0; k < 7; k++) ch[k] = 12'(12'h100 * k + 12'h023);
    drive_adc(ch);
    start = 1'b1;
    recv_frame(build_frame(ch, seq), 50, -1, 1'b0, 1'b0, "t2");
    seq++;

    // Snapshot isolation: live inputs randomised every cycle after the trigger.
    ch = rand_chans();
    drive_adc(ch);
    start = 1'b1;
    recv_frame(build_frame(ch, seq), 60, -1, 1'b0, 1'b1, "t3");
    seq++;

    // Overrun during byte 5 and in the last-accept cycle.
    ch = rand_chans();
    drive_adc(ch);
    start = 1'b1;
    recv_frame(build_frame(ch, seq), 70, 5, 1'b1, 1'b1, "t4");
    seq++;

    // Random frames under random backpressure.
    for (int n = 0; n < 4; n++) begin
      ch = rand_chans();
      drive_adc(ch);
      start = 1'b1;
      recv_frame(build_frame(ch, seq), 30 + 20 * n, -1, 1'b0, 1'b0, $sformatf("rnd%0d", n));
      seq++;
    end

    // Reset mid-frame at byte 9.
    ch = rand_chans();
    drive_adc(ch);
    expf = build_frame(ch, seq);
    tx_ready = 1'b1;
    start = 1'b1;
    @(negedge c1m);
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t6 byte%0d", i), 32'(tx_data), 32'(expf[i]));
      @(negedge c1m);
    end
    chk("t6 byte9", 32'(tx_data), 32'(expf[9]));
    rst = 1'b1;
    start = 1'b1;
    @(negedge c1m);
    chk("t6 valid-after-rst", 32'(tx_valid), 32'd0);
    chk("t6 data-after-rst", 32'(tx_data), 32'h00);
    chk("t6 busy-after-rst", 32'(busy), 32'd0);
    chk("t6 no-frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge c1m);
    chk("t6 idle-after-rst", 32'(tx_valid), 32'd0);
    chk("t6 no-late-frame_done", 32'(frame_done), 32'd0);
    seq = 8'd0;
    ch = rand_chans();
    drive_adc(ch);
    start = 1'b1;
    recv_frame(build_frame(ch, seq), 100, -1, 1'b0, 1'b0, "t6-after");

    // Periodic operation on the PERIOD=20 instance, through a seq wrap.
    pch = rand_chans();
    for (int k = 0; k < 7; k++) adc_p[k] = pch[k];
    @(negedge c1m);
    rst_p = 1'b0;
    cyc = 0; bi = 0; fn = 0; dones = 0;
    while (fn < 257 && cyc < 5400) begin
      @(negedge c1m);
      cyc++;
      if (frame_done_p) dones++;
      chk("p overrun", 32'(overrun_p), 32'd0);
      chk("p busy-vs-valid", 32'(busy_p), 32'(tx_valid_p));
      if (tx_valid_p) begin
        if (bi == 0) begin
          chk($sformatf("p frame%0d start-cycle", fn), 32'(cyc), 32'(20 * (fn + 1)));
          expf = build_frame(pch, 8'(fn));
          pch = rand_chans();
          for (int k = 0; k < 7; k++) adc_p[k] = pch[k];
        end
        chk($sformatf("p frame%0d byte%0d", fn, bi), 32'(tx_data_p), 32'(expf[bi]));
        bi++;
        if (bi == 17) begin
          bi = 0;
          fn++;
        end
      end
    end
    chk("p frames-within-budget", 32'(fn), 32'd257);
    @(negedge c1m);
    if (frame_done_p) dones++;
    chk("p frame_done count", 32'(dones), 32'd257);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
